// File: rtl/qif_neuron_array.sv
// Time-multiplexed array of quadratic integrate-and-fire neurons sharing one
// update datapath; channels are visited round-robin, one per enabled cycle.
module qif_neuron_array #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned FRAC    = 4,
    parameter int          V_PEAK  = 100,
    parameter int          V_RESET = -20,
    parameter int unsigned REFRAC  = 3,
    parameter int unsigned RW      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       cur_we,
    input  logic [$clog2(N_CH)-1:0]    cur_addr,
    input  logic [W-1:0]               cur_data,
    input  logic [$clog2(N_CH)-1:0]    v_sel_addr,
    output logic [W-1:0]               v_sel_out,
    output logic [N_CH-1:0]            spike_out,
    output logic                       step_done
);

    localparam int unsigned AW = $clog2(N_CH);
    localparam int unsigned SW = 2 * W + 2;

    localparam logic signed [W-1:0]  VRST = W'(V_RESET);
    localparam logic signed [W-1:0]  VPK  = W'(V_PEAK);
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (W - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(1 << (W - 1)));
    localparam logic [RW-1:0]        RFR  = RW'(REFRAC);
    localparam logic [AW-1:0]        LAST = AW'(N_CH - 1);

    logic signed [W-1:0] r_v   [N_CH];
    logic signed [W-1:0] r_i   [N_CH];
    logic [RW-1:0]       r_ref [N_CH];
    logic [AW-1:0]       r_ch;
    logic [N_CH-1:0]     r_acc;

    logic signed [SW-1:0] w_vx;
    logic signed [SW-1:0] w_ix;
    logic signed [SW-1:0] w_sq;
    logic signed [SW-1:0] w_sum;
    logic signed [W-1:0]  w_sat;
    logic signed [W-1:0]  w_v_nxt;
    logic [RW-1:0]        w_ref_nxt;
    logic                 w_spike;
    logic [N_CH-1:0]      w_spk_vec;

    // Shared neuron update for the channel currently selected by the scheduler
    always_comb begin
        w_vx      = {{(SW - W){r_v[r_ch][W-1]}}, r_v[r_ch]};
        w_ix      = {{(SW - W){r_i[r_ch][W-1]}}, r_i[r_ch]};
        w_sq      = (w_vx * w_vx) >>> FRAC;
        w_sum     = w_vx + w_sq + w_ix;
        w_sat     = w_sum[W-1:0];
        w_spike   = 1'b0;
        w_v_nxt   = w_sat;
        w_ref_nxt = r_ref[r_ch];
        w_spk_vec = '0;

        if (w_sum > SMAX) begin
            w_sat = SMAX[W-1:0];
        end else if (w_sum < SMIN) begin
            w_sat = SMIN[W-1:0];
        end
        w_v_nxt = w_sat;

        // Refractory channels are clamped at reset and never fire
        if (r_ref[r_ch] != '0) begin
            w_ref_nxt = r_ref[r_ch] - RW'(1);
            w_v_nxt   = VRST;
        end else if (w_sat >= VPK) begin
            w_spike   = 1'b1;
            w_v_nxt   = VRST;
            w_ref_nxt = RFR;
        end

        if (w_spike) begin
            w_spk_vec = N_CH'(1) << r_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                r_v[k]   <= VRST;
                r_i[k]   <= '0;
                r_ref[k] <= '0;
            end
            r_ch      <= '0;
            r_acc     <= '0;
            spike_out <= '0;
            step_done <= 1'b0;
            v_sel_out <= '0;
        end else begin
            v_sel_out <= r_v[v_sel_addr];
            step_done <= 1'b0;

            // Current writes land after the update read, so a same-cycle write uses old I
            if (cur_we) begin
                r_i[cur_addr] <= cur_data;
            end

            if (ena) begin
                r_ch        <= r_ch + AW'(1);
                r_v[r_ch]   <= w_v_nxt;
                r_ref[r_ch] <= w_ref_nxt;
                if (r_ch == LAST) begin
                    spike_out <= r_acc | w_spk_vec;
                    step_done <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc <= r_acc | w_spk_vec;
                end
            end
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// Scoreboard bench for qif_neuron_array: each expected sweep result is queued
// when its stimulus is driven and compared when step_done pulses.
module tb_qif_neuron_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena = 1'b0;
    logic       cur_we = 1'b0;
    logic [1:0] cur_addr = 2'd0;
    logic [7:0] cur_data = 8'd0;
    logic [1:0] v_sel_addr = 2'd0;
    logic [7:0] v_sel_out;
    logic [3:0] spike_out;
    logic       step_done;

    typedef struct packed {
        logic [3:0] spk;
        logic       chk_v;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    qif_neuron_array #(
        .N_CH(4), .W(8), .FRAC(4), .V_PEAK(100), .V_RESET(-20), .REFRAC(3), .RW(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .cur_we(cur_we),
        .cur_addr(cur_addr),
        .cur_data(cur_data),
        .v_sel_addr(v_sel_addr),
        .v_sel_out(v_sel_out),
        .spike_out(spike_out),
        .step_done(step_done)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every completed sweep must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && step_done === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected_step_done: got step_done=1, required no pending sweep");
            end else begin
                n_pass++;
                m_e = sb.pop_front();
                n_chk++;
                if (spike_out !== m_e.spk)
                    $display("FAIL sb_spike_out: got %b required %b", spike_out, m_e.spk);
                else
                    n_pass++;
                if (m_e.chk_v) begin
                    n_chk++;
                    if (v_sel_out !== m_e.v)
                        $display("FAIL sb_v_sel_out[%0d]: got %0d required %0d",
                                 v_sel_addr, $signed(v_sel_out), $signed(m_e.v));
                    else
                        n_pass++;
                end
            end
        end
    end

    function automatic void push(input logic [3:0] s, input logic c, input logic [7:0] v);
        exp_t e;
        e.spk = s;
        e.chk_v = c;
        e.v = v;
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        rst_n  = 1'b0;
        ena    = 1'b0;
        cur_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cur_we   = 1'b1;
        cur_addr = a;
        cur_data = d;
        @(negedge clk);
        cur_we = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        ena = 1'b1;
        repeat (n) @(negedge clk);
        ena = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0)
            $display("FAIL %s_drain: got %0d sweeps still pending, required 0", name, sb.size());
        else
            n_pass++;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        v_sel_addr = 2'd2;
        @(negedge clk);
        n_chk++; if (spike_out !== 4'b0) $display("FAIL rst_spike_out: got %b required 0000", spike_out); else n_pass++;
        n_chk++; if (step_done !== 1'b0) $display("FAIL rst_step_done: got %b required 0", step_done); else n_pass++;
        n_chk++; if (v_sel_out !== 8'h00) $display("FAIL rst_v_sel_out: got %h required 00", v_sel_out); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (v_sel_out !== 8'hEC) $display("FAIL rst_release_v: got %h required ec", v_sel_out); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (step_done !== 1'b0) $display("FAIL rst_idle_step_done: got %b required 0", step_done); else n_pass++;
        n_chk++; if (spike_out !== 4'b0) $display("FAIL rst_idle_spike: got %b required 0000", spike_out); else n_pass++;
    endtask

    task automatic test_zero_current();
        int vexp[11] = '{5, 6, 8, 12, 21, 48, -20, -20, -20, -20, 5};
        do_reset();
        v_sel_addr = 2'd0;
        for (int k = 0; k < 11; k++)
            push((k == 6) ? 4'b1111 : 4'b0000, 1'b1, 8'(vexp[k]));
        run_cycles(44);
        drain("zero_current");
    endtask

    task automatic test_drive_period();
        int sexp[9] = '{2, 0, 0, 0, 2, 0, 13, 0, 2};
        do_reset();
        v_sel_addr = 2'd1;
        wr(2'd1, 8'd100);
        for (int k = 0; k < 9; k++)
            push(4'(sexp[k]), 1'b1, 8'hEC);
        ena = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            n_chk++;
            if (step_done !== ((k % 4) == 3))
                $display("FAIL drive_step_done_c%0d: got %b required %b", k, step_done, ((k % 4) == 3));
            else
                n_pass++;
        end
        ena = 1'b0;
        drain("drive_period");
    endtask

    task automatic test_saturate();
        do_reset();
        v_sel_addr = 2'd2;
        wr(2'd2, 8'h80);
        push(4'b0000, 1'b1, 8'(-123));
        push(4'b0100, 1'b1, 8'hEC);
        run_cycles(8);
        drain("saturate");
    endtask

    task automatic test_freeze();
        do_reset();
        v_sel_addr = 2'd0;
        push(4'b0000, 1'b1, 8'd5);
        push(4'b0000, 1'b1, 8'd6);
        run_cycles(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (step_done !== 1'b0 || v_sel_out !== 8'd5)
                $display("FAIL freeze_c%0d: got step_done=%b v=%0d required 0 and 5", k, step_done, $signed(v_sel_out));
            else
                n_pass++;
        end
        ena = 1'b1;
        @(negedge clk);
        n_chk++; if (step_done !== 1'b0) $display("FAIL freeze_resume_early: got %b required 0", step_done); else n_pass++;
        @(negedge clk);
        n_chk++; if (step_done !== 1'b1) $display("FAIL freeze_resume_done: got %b required 1", step_done); else n_pass++;
        repeat (4) @(negedge clk);
        ena = 1'b0;
        drain("freeze");
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        v_sel_addr = 2'd0;
        wr(2'd0, 8'd100);
        wr(2'd1, 8'd80);
        wr(2'd3, 8'd80);
        push(4'b0001, 1'b1, 8'hEC);
        ena = 1'b1;
        repeat (7) @(negedge clk);
        n_chk++; if (spike_out !== 4'b0001) $display("FAIL mid_held_spike: got %b required 0001", spike_out); else n_pass++;
        rst_n = 1'b0;
        ena   = 1'b0;
        #1;
        n_chk++; if (spike_out !== 4'b0000) $display("FAIL mid_rst_spike: got %b required 0000", spike_out); else n_pass++;
        n_chk++; if (v_sel_out !== 8'h00) $display("FAIL mid_rst_v: got %h required 00", v_sel_out); else n_pass++;
        @(negedge clk);
        rst_n      = 1'b1;
        v_sel_addr = 2'd3;
        @(negedge clk);
        n_chk++; if (v_sel_out !== 8'hEC) $display("FAIL mid_v3_reset: got %0d required -20", $signed(v_sel_out)); else n_pass++;
        v_sel_addr = 2'd0;
        push(4'b0000, 1'b1, 8'd5);
        ena = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_chk++;
            if (step_done !== (k == 3))
                $display("FAIL mid_restart_c%0d: got %b required %b", k, step_done, (k == 3));
            else
                n_pass++;
        end
        ena = 1'b0;
        drain("reset_mid");
    endtask

    task automatic test_same_cycle_write();
        do_reset();
        v_sel_addr = 2'd0;
        push(4'b0000, 1'b1, 8'd5);
        push(4'b0001, 1'b1, 8'hEC);
        ena      = 1'b1;
        cur_we   = 1'b1;
        cur_addr = 2'd0;
        cur_data = 8'd100;
        @(negedge clk);
        cur_we = 1'b0;
        repeat (7) @(negedge clk);
        ena = 1'b0;
        drain("same_cycle_write");
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_zero_current();
        test_drive_period();
        test_saturate();
        test_freeze();
        test_reset_mid_sweep();
        test_same_cycle_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
